// File: rtl/lsu_seq.sv
// Sequential load/store unit: one memory op per handshake, req/gnt/rvalid bus, extended load writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses instead of aligning them).

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`endif
`ifndef LB
`define LB      4'd1
`endif
`ifndef LH
`define LH      4'd2
`endif
`ifndef LW
`define LW      4'd3
`endif
`ifndef LBU
`define LBU     4'd4
`endif
`ifndef LHU
`define LHU     4'd5
`endif
`ifndef SB
`define SB      4'd6
`endif
`ifndef SH
`define SH      4'd7
`endif
`ifndef SW
`define SW      4'd8
`endif

module lsu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [3:0]            req_op_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  busy_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [BE_WIDTH-1:0]   bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_err_i,
    output logic                  wb_we_o,
    output logic [4:0]            wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  err_o
);

    localparam int OFF_W = $clog2(BE_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Access size encoding: 0 byte, 1 half, 2 word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    logic [1:0]       state_reg;
    logic [1:0]       size_reg;
    logic             sign_reg;
    logic             load_reg;
    logic [OFF_W-1:0] off_reg;
    logic [4:0]       rd_reg;

    logic             op_valid;
    logic             op_load;
    logic             op_signed;
    logic [1:0]       op_size;
    logic             accept;
    logic             misalign_trap;

    logic [OFF_W-1:0]      off_raw;
    logic [OFF_W-1:0]      off_eff;
    logic [BE_WIDTH-1:0]   be_base;
    logic [BE_WIDTH-1:0]   be_new;
    logic [DATA_WIDTH-1:0] wdata_shift;
    logic [DATA_WIDTH-1:0] wdata_lane;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  sign_fill;

    assign req_ready_o = (state_reg == ST_IDLE) && !busy_o;
    assign accept      = req_valid_i && req_ready_o;

    // Unknown op codes decode exactly like MEM_NOP: accepted and dropped.
    always_comb begin
        op_valid  = 1'b0;
        op_load   = 1'b0;
        op_signed = 1'b0;
        op_size   = SZ_BYTE;
        case (req_op_i)
            `LB:  begin op_valid = 1'b1; op_load = 1'b1; op_signed = 1'b1; op_size = SZ_BYTE; end
            `LH:  begin op_valid = 1'b1; op_load = 1'b1; op_signed = 1'b1; op_size = SZ_HALF; end
            `LW:  begin op_valid = 1'b1; op_load = 1'b1; op_signed = 1'b1; op_size = SZ_WORD; end
            `LBU: begin op_valid = 1'b1; op_load = 1'b1; op_size = SZ_BYTE; end
            `LHU: begin op_valid = 1'b1; op_load = 1'b1; op_size = SZ_HALF; end
            `SB:  begin op_valid = 1'b1; op_size = SZ_BYTE; end
            `SH:  begin op_valid = 1'b1; op_size = SZ_HALF; end
            `SW:  begin op_valid = 1'b1; op_size = SZ_WORD; end
            default: ;
        endcase
    end

    assign off_raw = req_addr_i[OFF_W-1:0];

    always_comb begin
        off_eff = off_raw;
        if (op_size == SZ_HALF) begin
            off_eff[0] = 1'b0;
        end else if (op_size == SZ_WORD) begin
            off_eff[1:0] = 2'b00;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap = ((op_size == SZ_HALF) && off_raw[0]) ||
                           ((op_size == SZ_WORD) && (off_raw[1:0] != 2'b00));
`else
    assign misalign_trap = 1'b0;
`endif

    always_comb begin
        case (op_size)
            SZ_BYTE: be_base = BE_WIDTH'(4'b0001);
            SZ_HALF: be_base = BE_WIDTH'(4'b0011);
            default: be_base = BE_WIDTH'(4'b1111);
        endcase
    end

    assign be_new      = be_base << off_eff;
    assign wdata_shift = req_wdata_i << {off_eff, 3'b000};

    // Lanes outside the enabled bytes are driven to zero rather than carrying stray store bits.
    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_wlane
            assign wdata_lane[gi*8 +: 8] = be_new[gi] ? wdata_shift[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign rdata_shift = bus_rdata_i >> {off_reg, 3'b000};

    always_comb begin
        case (size_reg)
            SZ_BYTE: sign_fill = sign_reg & rdata_shift[7];
            SZ_HALF: sign_fill = sign_reg & rdata_shift[15];
            default: sign_fill = sign_reg & rdata_shift[31];
        endcase
    end

    // Each result bit is either a returned data bit or the extension fill, depending on access size.
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_ext
            if (gi < 8) begin : g_byte
                assign load_ext[gi] = rdata_shift[gi];
            end else if (gi < 16) begin : g_half
                assign load_ext[gi] = (size_reg != SZ_BYTE) ? rdata_shift[gi] : sign_fill;
            end else if (gi < 32) begin : g_word
                assign load_ext[gi] = (size_reg == SZ_WORD) ? rdata_shift[gi] : sign_fill;
            end else begin : g_upper
                assign load_ext[gi] = sign_fill;
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg   <= ST_IDLE;
            size_reg    <= SZ_BYTE;
            sign_reg    <= 1'b0;
            load_reg    <= 1'b0;
            off_reg     <= '0;
            rd_reg      <= '0;
            busy_o      <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            wb_we_o     <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            err_o       <= 1'b0;
        end else begin
            wb_we_o <= 1'b0;
            err_o   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept && op_valid) begin
                        busy_o <= 1'b1;
                        if (misalign_trap) begin
                            err_o <= 1'b1;
                        end else begin
                            state_reg   <= ST_REQ;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= !op_load;
                            bus_addr_o  <= {req_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                            bus_be_o    <= be_new;
                            bus_wdata_o <= wdata_lane;
                            size_reg    <= op_size;
                            sign_reg    <= op_signed;
                            load_reg    <= op_load;
                            off_reg     <= off_eff;
                            rd_reg      <= req_rd_i;
                        end
                    end else begin
                        // Busy covers the response-pulse cycle, then drops here.
                        busy_o <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_rvalid_i) begin
                        state_reg <= ST_IDLE;
                        if (bus_err_i) begin
                            err_o <= 1'b1;
                        end else if (load_reg) begin
                            wb_we_o   <= 1'b1;
                            wb_rd_o   <= rd_reg;
                            wb_data_o <= load_ext;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_seq.sv
// Scoreboard bench for lsu_seq: driver pushes expected bus and response items, monitors pop and compare.

`ifndef MEM_NOP
`define MEM_NOP 4'd0
`endif
`ifndef LB
`define LB      4'd1
`endif
`ifndef LH
`define LH      4'd2
`endif
`ifndef LW
`define LW      4'd3
`endif
`ifndef LBU
`define LBU     4'd4
`endif
`ifndef LHU
`define LHU     4'd5
`endif
`ifndef SB
`define SB      4'd6
`endif
`ifndef SH
`define SH      4'd7
`endif
`ifndef SW
`define SW      4'd8
`endif

module tb_lsu_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = 4'd0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        busy_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_err_i = 1'b0;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        err_o;

    lsu_seq dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .busy_o(busy_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
        .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          cyc;
    } bus_exp_t;

    typedef struct {
        logic        is_err;
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on sizes and offsets.
    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            `LB, `LBU, `SB: return 1;
            `LH, `LHU, `SH: return 2;
            `LW, `SW:       return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return (op == `SB) || (op == `SH) || (op == `SW);
    endfunction

    function automatic bit op_sext(input logic [3:0] op);
        return (op == `LB) || (op == `LH) || (op == `LW);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input int off, input int sz, input bit sgn);
        longint unsigned v;
        longint unsigned span;
        span = 64'd1 << (8 * sz);
        v = rdata;
        v = (v >> (8 * off)) % span;
        if (sgn && v >= (span >> 1)) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    // Monitors: sampled on the falling edge, away from the active edge.
    bus_exp_t  mon_b;
    resp_exp_t mon_r;
    logic      prev_req = 1'b0;
    logic      prev_gnt = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_be;
    logic        held_we;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            prev_req = 1'b0;
            prev_gnt = 1'b0;
        end else begin
            if (prev_req && prev_gnt) chk("bus_req_drop_after_gnt", bus_req_o, 1'b0);
            if (bus_req_o && !(prev_req && prev_gnt)) begin
                if (!prev_req) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected_req", bus_req_o, 1'b0);
                    end else begin
                        mon_b = bus_q.pop_front();
                        chk("bus_start_cycle", 64'(cyc), 64'(mon_b.cyc));
                        chk("bus_addr", bus_addr_o, mon_b.addr);
                        chk("bus_be", bus_be_o, mon_b.be);
                        chk("bus_we", bus_we_o, mon_b.we);
                        if (mon_b.we) chk("bus_wdata", bus_wdata_o, mon_b.wdata);
                    end
                    held_addr = bus_addr_o; held_be = bus_be_o;
                    held_wdata = bus_wdata_o; held_we = bus_we_o;
                end else begin
                    chk("bus_stable", {held_we, held_be, held_addr, held_wdata} == {bus_we_o, bus_be_o, bus_addr_o, bus_wdata_o}, 1'b1);
                end
            end
            prev_req = bus_req_o;
            prev_gnt = bus_gnt_i;

            if (wb_we_o || err_o) begin
                if (resp_q.size() == 0) begin
                    chk("resp_unexpected", {wb_we_o, err_o}, 2'b00);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(mon_r.cyc));
                    chk("resp_err", err_o, mon_r.is_err);
                    chk("resp_wb_we", wb_we_o, !mon_r.is_err);
                    if (!mon_r.is_err) begin
                        chk("wb_rd", wb_rd_o, mon_r.rd);
                        chk("wb_data", wb_data_o, mon_r.data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input logic [31:0] rdata, input logic err,
                          input int gnt_dly, input int rv_dly);
        int n;
        int sz;
        int off;
        bit trap;
        bit pulse;
        longint unsigned wexp;
        bus_exp_t  b;
        resp_exp_t r;
        n = 0;
        while (!req_ready_o && n < 20) begin tick(); n++; end
        chk("ready_before_issue", req_ready_o, 1'b1);
        $display("txn op=%0d addr=%h wdata=%h rd=%0d rdata=%h err=%0b gnt_dly=%0d rv_dly=%0d",
                 op, addr, wdata, rd, rdata, err, gnt_dly, rv_dly);
        sz = op_bytes(op);
        off = addr % 4;
        trap = 1'b0;
        if (sz != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
            trap = (off % sz) != 0;
`endif
            off = off - (off % sz);
        end
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
        if (sz != 0 && !trap) begin
            wexp = (longint'(wdata) % (64'd1 << (8 * sz))) << (8 * off);
            b.addr = addr - (addr % 4);
            b.be = 4'((1 << sz) - 1) << off;
            b.wdata = wexp[31:0];
            b.we = op_store(op);
            b.cyc = cyc + 1;
            bus_q.push_back(b);
        end
        if (trap) begin
            r.is_err = 1'b1; r.rd = rd; r.data = '0; r.cyc = cyc + 1;
            resp_q.push_back(r);
        end
        tick();
        req_valid_i = 1'b0;
        if (sz == 0) begin
            chk("nop_ready", req_ready_o, 1'b1);
            chk("nop_busy", busy_o, 1'b0);
            return;
        end
        if (trap) begin
            chk("trap_busy", busy_o, 1'b1);
            tick();
            chk("trap_ready_after", req_ready_o, 1'b1);
            return;
        end
        for (int i = 0; i < gnt_dly; i++) begin
            chk("req_busy", busy_o, 1'b1);
            chk("req_not_ready", req_ready_o, 1'b0);
            req_valid_i = 1'($urandom);
            req_op_i = 4'($urandom);
            bus_rvalid_i = 1'($urandom);
            bus_err_i = 1'($urandom);
            bus_rdata_i = $urandom;
            tick();
        end
        req_valid_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        for (int i = 0; i < rv_dly; i++) tick();
        bus_rvalid_i = 1'b1; bus_rdata_i = rdata; bus_err_i = err;
        pulse = err || !op_store(op);
        if (pulse) begin
            r.is_err = err; r.rd = rd;
            r.data = exp_load(rdata, off, sz, op_sext(op));
            r.cyc = cyc + 1;
            resp_q.push_back(r);
        end
        tick();
        bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
        if (pulse) begin
            chk("pulse_busy", busy_o, 1'b1);
            chk("pulse_not_ready", req_ready_o, 1'b0);
        end
        tick();
        chk("ready_after_resp", req_ready_o, 1'b1);
    endtask

    task automatic reset_mid_wait();
        bus_exp_t b;
        while (!req_ready_o) tick();
        $display("txn reset-mid-wait LW addr=00004000");
        req_valid_i = 1'b1; req_op_i = `LW; req_addr_i = 32'h4000; req_rd_i = 5'd7;
        b.addr = 32'h4000; b.be = 4'hF; b.wdata = '0; b.we = 1'b0; b.cyc = cyc + 1;
        bus_q.push_back(b);
        tick();
        req_valid_i = 1'b0;
        bus_gnt_i = 1'b1;
        tick();
        bus_gnt_i = 1'b0;
        rst_i = 1'b0;
        tick();
        tick();
        chk("rst_outputs_zero", {busy_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
                                 wb_we_o, wb_rd_o, err_o}, '0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_ready", req_ready_o, 1'b1);
        rst_i = 1'b1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        tick();
        bus_rvalid_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_late_ready", req_ready_o, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] op;
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("reset_outputs_zero", {busy_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
                                   wb_we_o, wb_rd_o, wb_data_o, err_o}, '0);
        chk("reset_ready", req_ready_o, 1'b1);
        rst_i = 1'b1;
        tick();

        run_op(`SB,  32'h1003, 32'h0000_00A5, 5'd0, 32'h0, 1'b0, 0, 0);
        run_op(`LB,  32'h2002, 32'h0, 5'd5, 32'h0080_0000, 1'b0, 0, 0);
        run_op(`LBU, 32'h2002, 32'h0, 5'd5, 32'h0080_0000, 1'b0, 0, 0);
        run_op(`LH,  32'h0010, 32'h0, 5'd9, 32'h1234_8001, 1'b0, 3, 1);
        run_op(`LW,  32'h0020, 32'h0, 5'd3, 32'hDEAD_BEEF, 1'b1, 0, 0);
        run_op(`LW,  32'h0024, 32'h0, 5'd0, 32'hCAFE_F00D, 1'b0, 1, 0);
        run_op(`LW,  32'h3001, 32'h0, 5'd4, 32'h8765_4321, 1'b0, 0, 0);
        run_op(`SH,  32'h0042, 32'hFFFF_BEEF, 5'd0, 32'h0, 1'b0, 2, 2);
        run_op(`MEM_NOP, 32'h0050, 32'h0, 5'd1, 32'h0, 1'b0, 0, 0);
        run_op(4'hF, 32'h0054, 32'h0, 5'd1, 32'h0, 1'b0, 0, 0);
        reset_mid_wait();

        for (int t = 0; t < 200; t++) begin
            op = 4'($urandom_range(0, 10));
            run_op(op, $urandom, $urandom, 5'($urandom), $urandom,
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        for (int i = 0; i < 4; i++) tick();
        chk("bus_q_drained", 64'(bus_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
